// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants: FSM state encoding, default bit period,
// and the ASCII keys that the pattern generator decodes.
package uart_pkg;

  localparam int unsigned ClksPerBitDefault = 217;

  localparam logic [7:0] KEY_1 = 8'h31;
  localparam logic [7:0] KEY_2 = 8'h32;
  localparam logic [7:0] KEY_3 = 8'h33;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StCleanup,
    StBreakWait
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_keystroke_rx.sv
// 8N1 UART receiver: holds the last correctly framed byte on Keystroke and emits
// single-cycle strobes for good bytes and framing errors.
module uart_keystroke_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_Serial,
  output logic [7:0] Keystroke,
  output logic       RX_DV,
  output logic       Frame_Error
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      key_q, key_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_rx_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (RX_Serial),
    .q_o  (rx_s)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      key_q   <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      key_q   <= key_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        // Start bit must still be low at its centre, otherwise it was a glitch.
        if (cnt_q == HalfLast) state_d = rx_s ? StIdle : StData;
      end
      StData: begin
        if (cnt_q == BitLast && idx_q == 3'd7) state_d = StStop;
      end
      StStop: begin
        if (cnt_q == BitLast) state_d = rx_s ? StCleanup : StBreakWait;
      end
      StCleanup: begin
        state_d = StIdle;
      end
      StBreakWait: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    key_d   = key_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s) begin
            key_d = shift_q;
            dv_d  = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCleanup, StBreakWait: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign Keystroke   = key_q;
  assign RX_DV       = dv_q;
  assign Frame_Error = fe_q;

endmodule
